// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: branch condition codes,
// 2-bit BHT counter encodings and the BHT index-width helper.
package branch_resolve_unit_pkg;

    // funct3 encodings of the conditional branches
    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_funct3_e;

    // 2-bit saturating counter states; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    // Number of index bits needed to address a BHT of the given size
    function automatic int unsigned bht_idx_w(input int unsigned entries);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < entries) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one synchronous saturating write port.
module bht_2bit
    import branch_resolve_unit_pkg::*;
#(
    parameter  int unsigned ENTRIES = 64,
    localparam int unsigned IW      = bht_idx_w(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_taken,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic          wr_taken
);

    bht_state_e ctr [ENTRIES];
    bht_state_e rd_state;
    bht_state_e cur_state;
    bht_state_e nxt_state;

    // Read port: prediction is the counter MSB, no write bypass
    always_comb begin
        rd_state = ctr[rd_idx];
        rd_taken = (rd_state == WT) || (rd_state == ST);
    end

    // Saturating next state for the entry being written
    always_comb begin
        cur_state = ctr[wr_idx];
        nxt_state = cur_state;
        case (cur_state)
            SNT:     nxt_state = wr_taken ? WNT : SNT;
            WNT:     nxt_state = wr_taken ? WT  : SNT;
            WT:      nxt_state = wr_taken ? ST  : WNT;
            ST:      nxt_state = wr_taken ? ST  : WT;
            default: nxt_state = WNT;
        endcase
    end

    // Counter array: reset to weakly not-taken, update on write enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr[i] <= WNT;
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= nxt_state;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: evaluates conditional branches and JAL/JALR,
// registers the outcome, flags mispredicts against the fetch prediction,
// trains the BHT and keeps saturating branch/mispredict counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             is_branch_i,
    input  logic             is_jal_i,
    input  logic             is_jalr_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic             pred_taken_i,
    input  logic [XLEN-1:0]  pred_target_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  lookup_pc_i,
    output logic             lookup_taken_o,
    output logic             valid_o,
    output logic             taken_o,
    output logic [XLEN-1:0]  target_o,
    output logic [XLEN-1:0]  link_o,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             misalign_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] mp_count_o
);

    localparam int unsigned IW = bht_idx_w(BHT_ENTRIES);

    logic [XLEN:0]   diff_ext;
    logic [XLEN-1:0] diff;
    logic            eq;
    logic            ltu;
    logic            lt;
    logic            cond;
    logic            bad_f3;
    logic            illegal;
    logic            taken;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            misalign;
    logic            accept;
    logic            mispredict;
    logic [XLEN-1:0] redirect;
    logic            bht_we;
    logic            unused_lookup_bits;

    assign unused_lookup_bits = ^{lookup_pc_i[XLEN-1:IW+2], lookup_pc_i[1:0]};

    // Single subtractor gives equality, unsigned borrow and signed less-than
    always_comb begin
        diff_ext = {1'b0, rs1_i} - {1'b0, rs2_i};
        diff     = diff_ext[XLEN-1:0];
        ltu      = diff_ext[XLEN];
        eq       = (diff == '0);
        lt       = (rs1_i[XLEN-1] == rs2_i[XLEN-1]) ? diff[XLEN-1] : rs1_i[XLEN-1];
    end

    // Branch condition decode; unused funct3 codes resolve not-taken
    always_comb begin
        cond   = 1'b0;
        bad_f3 = 1'b0;
        case (funct3_i)
            BR_EQ:   cond = eq;
            BR_NE:   cond = ~eq;
            BR_LT:   cond = lt;
            BR_GE:   cond = ~lt;
            BR_LTU:  cond = ltu;
            BR_GEU:  cond = ~ltu;
            default: bad_f3 = 1'b1;
        endcase
    end

    // Outcome, target, link and mispredict for the instruction in EX
    always_comb begin
        illegal    = is_branch_i & bad_f3;
        taken      = is_jal_i | is_jalr_i | (is_branch_i & cond);
        jalr_sum   = rs1_i + imm_i;
        target     = is_jalr_i ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_i + imm_i);
        link       = pc_i + XLEN'(4);
        misalign   = taken & target[1];
        accept     = valid_i & ~flush_i;
        mispredict = accept & ~misalign & ~illegal &
                     ((taken != pred_taken_i) |
                      (taken & pred_taken_i & (target != pred_target_i)));
        redirect   = taken ? target : link;
        bht_we     = ~stall_i & accept & is_branch_i & ~illegal;
    end

    // Result register: loads every unstalled edge, flush only kills valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o       <= 1'b0;
            taken_o       <= 1'b0;
            target_o      <= '0;
            link_o        <= '0;
            mispredict_o  <= 1'b0;
            redirect_pc_o <= '0;
            misalign_o    <= 1'b0;
            illegal_o     <= 1'b0;
        end else if (!stall_i) begin
            valid_o       <= accept;
            taken_o       <= taken;
            target_o      <= target;
            link_o        <= link;
            mispredict_o  <= mispredict;
            redirect_pc_o <= redirect;
            misalign_o    <= misalign;
            illegal_o     <= illegal;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_o <= '0;
            mp_count_o <= '0;
        end else if (!stall_i) begin
            if (bht_we && (br_count_o != '1)) begin
                br_count_o <= br_count_o + CNT_W'(1);
            end
            if (mispredict && (mp_count_o != '1)) begin
                mp_count_o <= mp_count_o + CNT_W'(1);
            end
        end
    end

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (lookup_pc_i[IW+1:2]),
        .rd_taken (lookup_taken_o),
        .wr_en    (bht_we),
        .wr_idx   (pc_i[IW+1:2]),
        .wr_taken (taken)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int NBHT  = 16;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid_i = 1'b0, is_branch_i = 1'b0, is_jal_i = 1'b0, is_jalr_i = 1'b0;
    logic [2:0]       funct3_i = '0;
    logic [XLEN-1:0]  rs1_i = '0, rs2_i = '0, pc_i = '0, imm_i = '0;
    logic             pred_taken_i = 1'b0;
    logic [XLEN-1:0]  pred_target_i = '0;
    logic             stall_i = 1'b0, flush_i = 1'b0;
    logic [XLEN-1:0]  lookup_pc_i = '0;
    logic             lookup_taken_o, valid_o, taken_o, mispredict_o, misalign_o, illegal_o;
    logic [XLEN-1:0]  target_o, link_o, redirect_pc_o;
    logic [CNT_W-1:0] br_count_o, mp_count_o;

    branch_resolve_unit #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (NBHT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .is_branch_i    (is_branch_i),
        .is_jal_i       (is_jal_i),
        .is_jalr_i      (is_jalr_i),
        .funct3_i       (funct3_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .pc_i           (pc_i),
        .imm_i          (imm_i),
        .pred_taken_i   (pred_taken_i),
        .pred_target_i  (pred_target_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .lookup_pc_i    (lookup_pc_i),
        .lookup_taken_o (lookup_taken_o),
        .valid_o        (valid_o),
        .taken_o        (taken_o),
        .target_o       (target_o),
        .link_o         (link_o),
        .mispredict_o   (mispredict_o),
        .redirect_pc_o  (redirect_pc_o),
        .misalign_o     (misalign_o),
        .illegal_o      (illegal_o),
        .br_count_o     (br_count_o),
        .mp_count_o     (mp_count_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    int              m_bht [NBHT];
    logic            e_valid, e_taken, e_mp, e_mis, e_ill;
    logic [XLEN-1:0] e_target, e_link, e_redir;
    int              e_br, e_mpc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_cond(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int m_idx(input logic [XLEN-1:0] pc);
        return int'((pc >> 2) % NBHT);
    endfunction

    function automatic logic [XLEN-1:0] m_target(input logic jalr, input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm);
        return jalr ? ((rs1 + imm) & ~32'd1) : (pc + imm);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NBHT; i++) m_bht[i] = 1;
        e_valid = 0; e_taken = 0; e_mp = 0; e_mis = 0; e_ill = 0;
        e_target = '0; e_link = '0; e_redir = '0; e_br = 0; e_mpc = 0;
    endtask

    task automatic compare_all();
        chk("valid_o",       valid_o,       e_valid);
        chk("taken_o",       taken_o,       e_taken);
        chk("target_o",      target_o,      e_target);
        chk("link_o",        link_o,        e_link);
        chk("mispredict_o",  mispredict_o,  e_mp);
        chk("redirect_pc_o", redirect_pc_o, e_redir);
        chk("misalign_o",    misalign_o,    e_mis);
        chk("illegal_o",     illegal_o,     e_ill);
        chk("br_count_o",    br_count_o,    e_br);
        chk("mp_count_o",    mp_count_o,    e_mpc);
    endtask

    // One clock: check lookup, predict the capture, clock, compare outputs.
    // Called at posedge+1 with inputs already applied.
    task automatic step();
        logic            t, ill, mis, acc, mp, upd;
        logic [XLEN-1:0] tgt, lnk;
        int              li, wi;
        #1;
        li = m_idx(lookup_pc_i);
        chk("lookup_taken_o", lookup_taken_o, m_bht[li] >= 2);
        t   = is_jal_i || is_jalr_i || (is_branch_i && m_cond(funct3_i, rs1_i, rs2_i));
        ill = is_branch_i && (funct3_i == 3'd2 || funct3_i == 3'd3);
        tgt = m_target(is_jalr_i, pc_i, rs1_i, imm_i);
        lnk = pc_i + 32'd4;
        mis = t && tgt[1];
        acc = valid_i && !flush_i;
        mp  = acc && !mis && !ill && ((t != pred_taken_i) || (t && pred_taken_i && tgt != pred_target_i));
        upd = acc && is_branch_i && !ill;
        wi  = m_idx(pc_i);
        @(posedge clk);
        #1;
        if (!stall_i) begin
            e_valid = acc; e_taken = t; e_target = tgt; e_link = lnk;
            e_mp = mp; e_redir = t ? tgt : lnk; e_mis = mis; e_ill = ill;
            if (upd) begin
                if (t && m_bht[wi] < 3) m_bht[wi]++;
                if (!t && m_bht[wi] > 0) m_bht[wi]--;
                if (e_br < CMAX) e_br++;
            end
            if (mp && e_mpc < CMAX) e_mpc++;
        end
        compare_all();
    endtask

    task automatic set_idle();
        valid_i = 0; is_branch_i = 0; is_jal_i = 0; is_jalr_i = 0; funct3_i = '0;
        stall_i = 0; flush_i = 0; pred_taken_i = 0; pred_target_i = '0;
    endtask

    task automatic set_branch(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
        set_idle();
        valid_i = 1; is_branch_i = 1; funct3_i = f;
        rs1_i = a; rs2_i = b; pc_i = pc; imm_i = imm; lookup_pc_i = pc;
    endtask

    // Asynchronous reset applied mid-cycle; called at posedge+1.
    task automatic do_reset();
        rst_n = 0;
        set_idle();
        #2;
        model_reset();
        compare_all();
        for (int i = 0; i < 3; i++) begin
            lookup_pc_i = $urandom;
            #1;
            chk("reset_lookup", lookup_taken_o, 1'b0);
        end
        #1;
        rst_n = 1;
    endtask

    task automatic rand_inputs();
        int kind;
        kind = $urandom_range(0, 3);
        valid_i     = ($urandom_range(0, 7) != 0);
        is_branch_i = (kind == 1);
        is_jal_i    = (kind == 2);
        is_jalr_i   = (kind == 3);
        funct3_i    = 3'($urandom_range(0, 7));
        rs1_i       = $urandom;
        case ($urandom_range(0, 3))
            0:       rs2_i = rs1_i;
            1:       rs2_i = rs1_i ^ 32'h8000_0000;
            default: rs2_i = $urandom;
        endcase
        pc_i         = $urandom & 32'h0000_0FFC;
        imm_i        = $urandom_range(0, 1) ? ($urandom & 32'h0000_00FE) : $urandom;
        pred_taken_i = $urandom_range(0, 1);
        pred_target_i = $urandom_range(0, 1) ? m_target(is_jalr_i, pc_i, rs1_i, imm_i) : $urandom;
        stall_i     = ($urandom_range(0, 7) == 0);
        flush_i     = ($urandom_range(0, 9) == 0);
        lookup_pc_i = $urandom_range(0, 1) ? pc_i : ($urandom & 32'h0000_0FFC);
    endtask

    logic [2:0] legal_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] mat_f3   [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd1, 3'd0};
    logic       mat_exp  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       sat_exp  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Mispredict: BEQ taken, predicted not-taken
        set_branch(3'd0, 32'd5, 32'd5, 32'h100, 32'h20);
        step();
        chk("mp_valid",    valid_o,       1'b1);
        chk("mp_taken",    taken_o,       1'b1);
        chk("mp_flag",     mispredict_o,  1'b1);
        chk("mp_redirect", redirect_pc_o, 32'h120);
        chk("mp_count",    mp_count_o,    8'd1);

        // Stall three cycles with changing inputs; flush ignored while stalled
        for (int i = 0; i < 3; i++) begin
            set_branch(3'd1, $urandom, $urandom, $urandom & 32'hFFC, 32'h8);
            stall_i = 1;
            flush_i = (i == 1);
            step();
            chk("stall_valid",    valid_o,       1'b1);
            chk("stall_redirect", redirect_pc_o, 32'h120);
            chk("stall_br",       br_count_o,    8'd1);
            chk("stall_mp",       mp_count_o,    8'd1);
        end

        // Flush beats valid: no result, no BHT or counter change
        set_branch(3'd0, 32'd7, 32'd7, 32'h100, 32'h20);
        flush_i = 1;
        step();
        chk("flush_valid", valid_o,    1'b0);
        chk("flush_br",    br_count_o, 8'd1);
        chk("flush_mp",    mp_count_o, 8'd1);
        lookup_pc_i = 32'h100;
        #1;
        chk("flush_bht", lookup_taken_o, 1'b1);

        // JALR aligned target, correctly predicted
        set_idle();
        valid_i = 1; is_jalr_i = 1; pc_i = 32'h300; rs1_i = 32'h1001; imm_i = 32'h3;
        pred_taken_i = 1; pred_target_i = 32'h1004;
        step();
        chk("jalr_target", target_o,     32'h1004);
        chk("jalr_link",   link_o,       32'h304);
        chk("jalr_mp",     mispredict_o, 1'b0);
        // JALR misaligned target suppresses mispredict
        imm_i = 32'h1;
        step();
        chk("jalr_mis_target", target_o,     32'h1002);
        chk("jalr_misalign",   misalign_o,   1'b1);
        chk("jalr_mis_mp",     mispredict_o, 1'b0);

        // BHT saturation at 0x40
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_branch(3'd0, 32'd9, 32'd9, 32'h40, 32'h10);
            #1;
            chk("bht_sat_lookup", lookup_taken_o, sat_exp[i]);
            step();
        end
        set_branch(3'd1, 32'd9, 32'd9, 32'h40, 32'h10);
        #1;
        chk("bht_old_value", lookup_taken_o, 1'b1);
        step();
        #1;
        chk("bht_after_nt", lookup_taken_o, 1'b1);
        chk("bht_br_count", br_count_o, 8'd5);

        // Compare matrix
        for (int i = 0; i < 6; i++) begin
            set_branch(mat_f3[i], 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10);
            step();
            chk("matrix_taken", taken_o, mat_exp[i]);
        end
        set_branch(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h200, 32'h10);
        step();
        chk("beq_min_taken", taken_o, 1'b1);
        set_branch(3'd2, 32'd1, 32'd1, 32'h200, 32'h10);
        step();
        chk("illegal_flag", illegal_o, 1'b1);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            set_branch(legal_f3[$urandom_range(0, 5)], $urandom, $urandom, $urandom & 32'hFFC, 32'h10);
            pred_taken_i = $urandom_range(0, 1);
            step();
        end
        chk("br_count_sat", br_count_o, 8'hFF);

        // Randomized traffic with occasional mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            rand_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
